// File: rtl/mac_feeder.sv
// Operand-pair buffer and sequencer for an external registered MAC: collects (x, w)
// pairs while idle, then streams them into the MAC and captures the accumulated result.
module mac_feeder #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [N-1:0]     wr_x,
    input  logic [N-1:0]     wr_w,
    output logic             wr_ready,
    input  logic             start,
    output logic             busy,
    output logic [N-1:0]     mac_x,
    output logic [N-1:0]     mac_w,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_out,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    input  logic             res_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

    state_t           state_reg;
    logic [2*N-1:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [N-1:0]     mac_x_reg;
    logic [N-1:0]     mac_w_reg;
    logic             mac_clr_reg;
    logic             res_valid_reg;
    logic [ACC_W-1:0] res_data_reg;
    logic             push;
    logic             pop;

    assign wr_ready  = (state_reg == IDLE) && (count_reg != CW'(DEPTH));
    assign busy      = (state_reg != IDLE);
    assign push      = wr_valid && wr_ready;
    // A pair leaves the buffer on the edge that loads it onto the MAC operand registers.
    assign pop       = ((state_reg == CLEAR) || (state_reg == FEED)) && (count_reg != '0);
    assign mac_x     = mac_x_reg;
    assign mac_w     = mac_w_reg;
    assign mac_clr   = mac_clr_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_x, wr_w};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            mac_x_reg     <= '0;
            mac_w_reg     <= '0;
            // Clear the external accumulator so no partial sum survives a mid-run reset.
            mac_clr_reg   <= 1'b1;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            mac_clr_reg <= 1'b0;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                count_reg  <= count_reg + CW'(1);
            end else if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg  <= count_reg - CW'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= CLEAR;
                        mac_clr_reg <= 1'b1;
                    end
                end
                CLEAR, FEED: begin
                    if (pop) begin
                        {mac_x_reg, mac_w_reg} <= mem[rd_ptr_reg];
                        state_reg              <= FEED;
                    end else begin
                        mac_x_reg <= '0;
                        mac_w_reg <= '0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    res_data_reg  <= mac_out;
                    res_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural registered MAC attached to its outputs.
module tb_mac_feeder;

    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [N-1:0]     wr_x;
    logic [N-1:0]     wr_w;
    logic             wr_ready;
    logic             start;
    logic             busy;
    logic [N-1:0]     mac_x;
    logic [N-1:0]     mac_w;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_out;
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic             res_ready;

    int vectors     = 0;
    int miscompares = 0;
    int qx[$];
    int qw[$];

    mac_feeder #(.N(N), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_w(wr_w), .wr_ready(wr_ready),
        .start(start), .busy(busy),
        .mac_x(mac_x), .mac_w(mac_w), .mac_clr(mac_clr), .mac_out(mac_out),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mac_clr) mac_out <= '0;
        else         mac_out <= mac_out + ACC_W'(mac_x) * ACC_W'(mac_w);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int w, input logic exp_ready);
        wr_valid = 1'b1;
        wr_x     = N'(x);
        wr_w     = N'(w);
        chk("wr_ready", wr_ready, exp_ready);
        if (exp_ready) begin
            qx.push_back(x);
            qw.push_back(w);
        end
        tick;
        wr_valid = 1'b0;
    endtask

    // Called right after the edge that sampled start; walks CLEAR, FEED, DRAIN, HOLD.
    task automatic finish_run(input int exp_sum, input int hold_cycles);
        int k;
        k = qx.size();
        chk("clear_cycle", mac_clr, 1'b1);
        chk("busy_run", busy, 1'b1);
        for (int i = 0; i < k; i++) begin
            tick;
            chk("feed_x", mac_x, qx[i]);
            chk("feed_w", mac_w, qw[i]);
            chk("feed_clr", mac_clr, 1'b0);
        end
        qx.delete();
        qw.delete();
        tick;
        chk("drain_valid", res_valid, 1'b0);
        chk("drain_x", mac_x, 0);
        tick;
        chk("hold_valid", res_valid, 1'b1);
        chk("res_data", res_data, exp_sum);
        for (int i = 0; i < hold_cycles; i++) begin
            start    = 1'b1;
            wr_valid = 1'b1;
            wr_x     = 8'd9;
            wr_w     = 8'd9;
            tick;
            chk("hold_stable_valid", res_valid, 1'b1);
            chk("hold_stable_data", res_data, exp_sum);
            chk("hold_busy", busy, 1'b1);
            chk("hold_wr_ready", wr_ready, 1'b0);
        end
        start     = 1'b0;
        wr_valid  = 1'b0;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("idle_valid", res_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic run(input int exp_sum, input int hold_cycles);
        start = 1'b1;
        tick;
        start = 1'b0;
        finish_run(exp_sum, hold_cycles);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_w = '0; start = 1'b0; res_ready = 1'b0;
        tick;
        tick;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_data", res_data, 0);
        chk("rst_mac_x", mac_x, 0);
        chk("rst_mac_clr", mac_clr, 1'b1);
        chk("rst_wr_ready", wr_ready, 1'b1);
        rst = 1'b0;
        tick;
        chk("idle_mac_clr", mac_clr, 1'b0);
        $display("reset checked");

        // Four pairs: 10 + 12 + 63 + 48
        push(5, 2, 1'b1); push(3, 4, 1'b1); push(7, 9, 1'b1); push(8, 6, 1'b1);
        run(133, 0);
        $display("run of 4 pairs checked");

        run(0, 0);
        $display("empty run checked");

        // Fill to DEPTH; the ninth pair is refused. 8 * 65025
        for (int i = 0; i < DEPTH; i++) push(255, 255, 1'b1);
        push(255, 255, 1'b0);
        run(520200, 0);
        $display("full buffer run checked");

        // Reset during the second FEED cycle of a 4-pair run.
        push(1, 2, 1'b1); push(3, 4, 1'b1); push(5, 6, 1'b1); push(7, 8, 1'b1);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("midrun_feed_x", mac_x, 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        qx.delete();
        qw.delete();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", res_valid, 1'b0);
        chk("midrst_data", res_data, 0);
        chk("midrst_mac_x", mac_x, 0);
        chk("midrst_mac_w", mac_w, 0);
        chk("midrst_mac_clr", mac_clr, 1'b1);
        chk("midrst_wr_ready", wr_ready, 1'b1);
        push(1, 1, 1'b1);
        run(1, 0);
        $display("mid-run reset checked");

        // Held result with start and writes offered during HOLD; nothing may be stored or queued.
        push(2, 3, 1'b1); push(4, 5, 1'b1);
        run(26, 5);
        tick;
        chk("no_queued_start", busy, 1'b0);
        run(0, 0);
        $display("hold back-pressure checked");

        // Write accepted on the same edge as start joins the run: 4 + 9 + 16
        push(2, 2, 1'b1); push(3, 3, 1'b1);
        wr_valid = 1'b1; wr_x = 8'd4; wr_w = 8'd4; start = 1'b1;
        chk("wr_ready_with_start", wr_ready, 1'b1);
        qx.push_back(4);
        qw.push_back(4);
        tick;
        wr_valid = 1'b0;
        start    = 1'b0;
        finish_run(29, 0);
        $display("write with start checked");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
